// File: rtl/rf_write_arbiter_if.sv
// Bundles the requester handshake and register-file write-port signals of
// rf_write_arbiter.
//   master : drives req_valid/req_addr/req_data/wr_stall; observes
//            req_ready/wr_data/conflict
//   slave  : the arbiter side (directions reversed)
// Flattened layouts: requester r uses req_addr[r*ADDR_W +: ADDR_W] and
// req_data[r*DATA_W +: DATA_W]; write port k uses
// wr_data[k*(DATA_W+ADDR_W+1) +: DATA_W+ADDR_W+1].
interface rf_write_arbiter_if #(
  parameter int NUM_REQ   = 4,
  parameter int NUM_PORTS = 3,
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 4
);
  logic [NUM_REQ-1:0]                          req_valid;
  logic [NUM_REQ*ADDR_W-1:0]                   req_addr;
  logic [NUM_REQ*DATA_W-1:0]                   req_data;
  logic [NUM_REQ-1:0]                          req_ready;
  logic                                        wr_stall;
  logic [NUM_PORTS*(DATA_W+ADDR_W+1)-1:0]      wr_data;
  logic                                        conflict;

  modport master (
    output req_valid, req_addr, req_data, wr_stall,
    input  req_ready, wr_data, conflict
  );

  modport slave (
    input  req_valid, req_addr, req_data, wr_stall,
    output req_ready, wr_data, conflict
  );
endinterface

// File: rtl/rf_write_arbiter.sv
// Round-robin arbiter that routes up to NUM_PORTS requester results per cycle
// onto registered register-file write ports, refusing any request that targets
// a register already written earlier in the same scan.
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   bus_if       : rf_write_arbiter_if.slave (requests, ready, stall,
//                  write-port words {value, index, enable}, conflict flag)
//   grant_count  : per-requester saturating grant counters (16 bits each),
//                  present only when RF_WRITE_ARB_STATS_EN is defined
module rf_write_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int NUM_PORTS = 3,
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  rf_write_arbiter_if.slave     bus_if
`ifdef RF_WRITE_ARB_STATS_EN
  ,
  output logic [NUM_REQ*16-1:0] grant_count
`endif
);

  localparam int WORD_W = DATA_W + ADDR_W + 1;
  localparam int PTR_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PTR_W-1:0]                    rr_ptr_q, rr_ptr_d;
  logic [NUM_PORTS-1:0][WORD_W-1:0]    wr_q, wr_d;
  logic                                conflict_q, conflict_d;
  logic [NUM_REQ-1:0]                  ready_d;

  // Scan scratch state
  logic [NUM_PORTS-1:0][ADDR_W-1:0]    gnt_addr;
  int unsigned                         n_gnt;
  int unsigned                         idx;
  logic                                hit;

  always_comb begin
    ready_d    = '0;
    wr_d       = '0;
    conflict_d = 1'b0;
    rr_ptr_d   = rr_ptr_q;
    gnt_addr   = '0;
    n_gnt      = 0;
    idx        = 0;
    hit        = 1'b0;
    if (!rst && !bus_if.wr_stall) begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        idx = 32'(rr_ptr_q) + i;
        if (idx >= NUM_REQ) idx = idx - NUM_REQ;
        // Address comparisons only happen while a port is still free; once all
        // ports are used the remaining requests are refused for capacity.
        if (bus_if.req_valid[idx] && (n_gnt < NUM_PORTS)) begin
          hit = 1'b0;
          for (int unsigned j = 0; j < NUM_PORTS; j++) begin
            if ((j < n_gnt) && (gnt_addr[j] == bus_if.req_addr[idx*ADDR_W +: ADDR_W]))
              hit = 1'b1;
          end
          if (hit) begin
            conflict_d = 1'b1;
          end else begin
            gnt_addr[n_gnt] = bus_if.req_addr[idx*ADDR_W +: ADDR_W];
            wr_d[n_gnt]     = {bus_if.req_data[idx*DATA_W +: DATA_W],
                               bus_if.req_addr[idx*ADDR_W +: ADDR_W], 1'b1};
            ready_d[idx]    = 1'b1;
            n_gnt           = n_gnt + 1;
            if (idx + 1 >= NUM_REQ) rr_ptr_d = '0;
            else                    rr_ptr_d = PTR_W'(idx + 1);
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q   <= '0;
      wr_q       <= '0;
      conflict_q <= 1'b0;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      wr_q       <= wr_d;
      conflict_q <= conflict_d;
    end
  end

  assign bus_if.req_ready = ready_d;
  assign bus_if.wr_data   = wr_q;
  assign bus_if.conflict  = conflict_q;

`ifdef RF_WRITE_ARB_STATS_EN
  logic [NUM_REQ-1:0][15:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (ready_d[i] && (cnt_q[i] != 16'hFFFF))
          cnt_q[i] <= cnt_q[i] + 16'd1;
      end
    end
  end

  assign grant_count = cnt_q;
`endif

endmodule

// File: tb/tb_rf_write_arbiter.sv
module tb_rf_write_arbiter;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  rf_write_arbiter_if #(.NUM_REQ(4), .NUM_PORTS(3), .DATA_W(16), .ADDR_W(4)) bus_if ();

`ifdef RF_WRITE_ARB_STATS_EN
  logic [4*16-1:0] grant_count;
`endif

  rf_write_arbiter #(.NUM_REQ(4), .NUM_PORTS(3), .DATA_W(16), .ADDR_W(4)) dut (
    .clk    (clk),
    .rst    (rst),
    .bus_if (bus_if)
`ifdef RF_WRITE_ARB_STATS_EN
    ,
    .grant_count (grant_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [20:0] w(input logic [15:0] d, input logic [3:0] a);
    return {d, a, 1'b1};
  endfunction

  // Advance one rising edge and settle before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst = 1'b1;
    bus_if.wr_stall  = 1'b0;
    bus_if.req_valid = 4'b0001;
    bus_if.req_addr  = {4'd0, 4'd0, 4'd0, 4'd7};
    bus_if.req_data  = {16'h0, 16'h0, 16'h0, 16'h7777};

    // Reset with req0 valid at addr 7
    tick();
    check("rst_ready", 64'(bus_if.req_ready), 64'h0);
    tick();
    check("rst_wr", 64'(bus_if.wr_data), 64'h0);
    check("rst_conflict", 64'(bus_if.conflict), 64'h0);
    check("rst_rr", 64'(dut.rr_ptr_q), 64'h0);
    rst = 1'b0;
    bus_if.req_valid = 4'b0000;
    tick();
    check("post_rst_wr", 64'(bus_if.wr_data), 64'h0);
    check("post_rst_rr", 64'(dut.rr_ptr_q), 64'h0);

    // All four valid, addrs 1..4, rr=0
    bus_if.req_valid = 4'b1111;
    bus_if.req_addr  = {4'd4, 4'd3, 4'd2, 4'd1};
    bus_if.req_data  = {16'h00A3, 16'h00A2, 16'h00A1, 16'h00A0};
    #1;
    check("all4_ready", 64'(bus_if.req_ready), 64'b0111);
    tick();
    check("all4_wr", 64'(bus_if.wr_data), 64'({w(16'hA2, 4'd3), w(16'hA1, 4'd2), w(16'hA0, 4'd1)}));
    check("all4_rr", 64'(dut.rr_ptr_q), 64'd3);
    check("all4_conflict", 64'(bus_if.conflict), 64'h0);

    // Held: scan 3,0,1
    check("rr3_ready", 64'(bus_if.req_ready), 64'b1011);
    tick();
    check("rr3_wr", 64'(bus_if.wr_data), 64'({w(16'hA1, 4'd2), w(16'hA0, 4'd1), w(16'hA3, 4'd4)}));
    check("rr3_rr", 64'(dut.rr_ptr_q), 64'd2);

    // Held: scan 2,3,0
    check("rr2_ready", 64'(bus_if.req_ready), 64'b1101);
    tick();
    check("rr2_wr", 64'(bus_if.wr_data), 64'({w(16'hA0, 4'd1), w(16'hA3, 4'd4), w(16'hA2, 4'd3)}));
    check("rr2_rr", 64'(dut.rr_ptr_q), 64'd1);

    // Stall with all valid
    bus_if.wr_stall = 1'b1;
    #1;
    check("stall_ready", 64'(bus_if.req_ready), 64'h0);
    tick();
    check("stall_wr", 64'(bus_if.wr_data), 64'h0);
    check("stall_rr", 64'(dut.rr_ptr_q), 64'd1);
    check("stall_conflict", 64'(bus_if.conflict), 64'h0);
    bus_if.wr_stall = 1'b0;

    // Only req3 valid: brings rr back to 0
    bus_if.req_valid = 4'b1000;
    #1;
    check("r3_ready", 64'(bus_if.req_ready), 64'b1000);
    tick();
    check("r3_wr", 64'(bus_if.wr_data), 64'({21'h0, 21'h0, w(16'hA3, 4'd4)}));
    check("r3_rr", 64'(dut.rr_ptr_q), 64'd0);

    // req0 and req1 both target addr 5
    bus_if.req_valid = 4'b0011;
    bus_if.req_addr  = {4'd4, 4'd3, 4'd5, 4'd5};
    bus_if.req_data  = {16'h00A3, 16'h00A2, 16'h2222, 16'h1111};
    #1;
    check("dup_ready", 64'(bus_if.req_ready), 64'b0001);
    tick();
    check("dup_wr", 64'(bus_if.wr_data), 64'({21'h0, 21'h0, w(16'h1111, 4'd5)}));
    check("dup_conflict", 64'(bus_if.conflict), 64'h1);
    check("dup_rr", 64'(dut.rr_ptr_q), 64'd1);

    // Idle: conflict clears, rr holds
    bus_if.req_valid = 4'b0000;
    #1;
    check("idle_ready", 64'(bus_if.req_ready), 64'h0);
    tick();
    check("idle_wr", 64'(bus_if.wr_data), 64'h0);
    check("idle_conflict", 64'(bus_if.conflict), 64'h0);
    check("idle_rr", 64'(dut.rr_ptr_q), 64'd1);

    // rr=1, addrs {6,9,9,9}: scan 1 grant, 2 refused, 3 grant, 0 refused
    bus_if.req_valid = 4'b1111;
    bus_if.req_addr  = {4'd6, 4'd9, 4'd9, 4'd9};
    bus_if.req_data  = {16'h0033, 16'h0022, 16'h0011, 16'h0000};
    #1;
    check("multi_ready", 64'(bus_if.req_ready), 64'b1010);
    tick();
    check("multi_wr", 64'(bus_if.wr_data), 64'({21'h0, w(16'h0033, 4'd6), w(16'h0011, 4'd9)}));
    check("multi_conflict", 64'(bus_if.conflict), 64'h1);
    check("multi_rr", 64'(dut.rr_ptr_q), 64'd0);

    // Invalid req1 shares addr with req0 and must not cause a refusal
    bus_if.req_valid = 4'b0101;
    bus_if.req_addr  = {4'd6, 4'd3, 4'd9, 4'd9};
    bus_if.req_data  = {16'h0033, 16'h0022, 16'h0011, 16'h0000};
    #1;
    check("inval_ready", 64'(bus_if.req_ready), 64'b0101);
    tick();
    check("inval_wr", 64'(bus_if.wr_data), 64'({21'h0, w(16'h0022, 4'd3), w(16'h0000, 4'd9)}));
    check("inval_conflict", 64'(bus_if.conflict), 64'h0);
    check("inval_rr", 64'(dut.rr_ptr_q), 64'd3);

`ifdef RF_WRITE_ARB_STATS_EN
    rst = 1'b1;
    bus_if.req_valid = 4'b0000;
    tick();
    rst = 1'b0;
    check("cnt_clear", 64'(grant_count), 64'h0);
    bus_if.req_valid = 4'b0001;
    for (int i = 0; i < 65537; i++) tick();
    bus_if.req_valid = 4'b0000;
    tick();
    check("cnt_sat", 64'(grant_count[15:0]), 64'hFFFF);
    check("cnt_other", 64'(grant_count[63:16]), 64'h0);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/rf_write_arbiter.md
RF_WRITE_ARBITER -- requirements
Module: rf_write_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of result requesters (legal range 1..8).
REQ-002 SHALL have parameter NUM_PORTS, default 3, number of register-file write ports driven.
REQ-003 SHALL have parameter DATA_W, default 16, register value width.
REQ-004 SHALL have parameter ADDR_W, default 4, register index width.
REQ-005 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-007 SHALL have port req_valid  input  NUM_REQ  per-requester result-valid flag.
REQ-008 SHALL have port req_addr  input  NUM_REQ x ADDR_W  per-requester destination register.
REQ-009 SHALL have port req_data  input  NUM_REQ x DATA_W  per-requester result value.
REQ-010 SHALL have port req_ready  output  NUM_REQ  per-requester accept flag, combinational.
REQ-011 SHALL have port wr_stall  input  1  when high, no grants are issued this cycle.
REQ-012 SHALL have port wr_data  output  NUM_PORTS x (DATA_W+ADDR_W+1)  registered write-port words.
REQ-013 SHALL have port conflict  output  1  registered; high when any valid request was refused in the previous cycle because of an address conflict.

Function
REQ-014 SHALL format each wr_data word as bit 0 = write enable, bits [ADDR_W:1] = register index, bits [DATA_W+ADDR_W:ADDR_W+1] = value.
REQ-015 SHALL accept a request when req_valid and req_ready are both high in the same cycle.
REQ-016 SHALL keep a round-robin pointer rr_ptr in 0..NUM_REQ-1 and scan requesters in order rr_ptr, rr_ptr+1, ..., wrapping modulo NUM_REQ.
REQ-017 SHALL grant, in scan order, at most NUM_PORTS valid requests per cycle.
REQ-018 SHALL refuse a valid request whose req_addr equals that of a request already granted earlier in the same scan; the refusal does not consume a port, and the scan continues.
REQ-019 SHALL hold req_ready low for every requester that is not granted, including requesters with req_valid low.
REQ-020 SHALL drive granted request k (k-th in scan order) onto wr_data port k on the next rising edge (one-cycle latency); unused ports SHALL be all-zero.
REQ-021 SHALL, after a cycle with at least one grant, set rr_ptr to (index of last granted requester + 1) mod NUM_REQ; with no grants rr_ptr SHALL hold.
REQ-022 SHALL, while wr_stall is high, drive all req_ready low, register all-zero wr_data, hold rr_ptr, and clear conflict.
REQ-023 SHALL set conflict on the next edge iff REQ-018 refused at least one valid request in the current cycle.
REQ-024 SHALL not depend on req_addr or req_data of requesters whose req_valid is low.

Reset
REQ-025 SHALL, while rst is high at a rising edge, set all wr_data to zero, conflict to 0 and rr_ptr to 0.
REQ-026 SHALL drive all req_ready low while rst is high; any request presented during reset SHALL not be accepted, and no write for it SHALL appear after reset.
REQ-027 SHALL produce all-zero wr_data in the first cycle after reset deassertion.

Configuration
REQ-028 SHALL, when macro RF_WRITE_ARB_STATS_EN is defined, add output grant_count (NUM_REQ x 16): per-requester saturating counters incremented on each grant, cleared by rst, held at 16'hFFFF once reached.
REQ-029 SHALL, without RF_WRITE_ARB_STATS_EN, omit grant_count and all counter logic; all other behaviour SHALL be identical.

Verification
REQ-030 SHALL cover: all 4 requesters valid, distinct addrs 1,2,3,4, rr_ptr=0 -> ready=4'b0111, next cycle ports carry addrs 1,2,3, rr_ptr=3.
REQ-031 SHALL cover: next cycle same 4 requests held -> requester 3 scanned first; ports carry addrs 4,1,2 (requesters 3,0,1), rr_ptr=2.
REQ-032 SHALL cover: req0 and req1 both addr 5 (data 16'h1111, 16'h2222), rr_ptr=0 -> only req0 ready; port0 = {16'h1111,4'd5,1'b1}; conflict=1 next cycle.
REQ-033 SHALL cover: wr_stall=1 with all requests valid -> ready=0, wr_data all zero, rr_ptr unchanged.
REQ-034 SHALL cover: rst asserted while req0 valid (addr 7) -> ready low, no addr-7 write after deassertion, rr_ptr=0.
REQ-035 SHALL cover (RF_WRITE_ARB_STATS_EN): requester 0 granted 65537 times -> grant_count[0]=16'hFFFF.
